// File: rtl/div_unit_pkg.sv
// Shared types and default sizing for the iterative divider.
package div_unit_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU: one quotient bit per clock on
// operand magnitudes, sign fix-up applied as the result register is loaded.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_start_i,
    input  logic                  div_signed_i,
    input  logic [DATA_W-1:0]     div_data1_i,
    input  logic [DATA_W-1:0]     div_data2_i,
    output logic [2*DATA_W-1:0]   div_result_o,
    output logic                  div_done_o
);

    // Two's-complement negate when neg is set; also serves as abs() on signed operands.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        logic [DATA_W-1:0] r;
        if (neg) begin
            r = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      rem_q, rem_d;
    logic [DATA_W-1:0]      dvd_q, dvd_d;
    logic [DATA_W-1:0]      dsr_q, dsr_d;
    logic                   q_neg_q, q_neg_d;
    logic                   r_neg_q, r_neg_d;
    logic [2*DATA_W-1:0]    result_q, result_d;
    logic                   done_q, done_d;

    logic [DATA_W:0]        rem_sh_s;
    logic [DATA_W:0]        trial_s;
    logic                   no_borrow_s;
    logic [DATA_W-1:0]      rem_step_s;
    logic [DATA_W-1:0]      dvd_step_s;

    // One restoring step: a set top bit of the trial means the divisor did not fit.
    assign rem_sh_s    = {rem_q, dvd_q[DATA_W-1]};
    assign trial_s     = rem_sh_s - {1'b0, dsr_q};
    assign no_borrow_s = ~trial_s[DATA_W];
    assign rem_step_s  = no_borrow_s ? trial_s[DATA_W-1:0] : rem_sh_s[DATA_W-1:0];
    assign dvd_step_s  = {dvd_q[DATA_W-2:0], no_borrow_s};

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (div_start_i) begin
                    dvd_d   = cond_neg(div_data1_i, div_signed_i & div_data1_i[DATA_W-1]);
                    dsr_d   = cond_neg(div_data2_i, div_signed_i & div_data2_i[DATA_W-1]);
                    q_neg_d = div_signed_i & (div_data1_i[DATA_W-1] ^ div_data2_i[DATA_W-1]);
                    r_neg_d = div_signed_i & div_data1_i[DATA_W-1];
                    rem_d   = {DATA_W{1'b0}};
                    cnt_d   = CNT_W'(DATA_W);
                    if (div_data2_i == {DATA_W{1'b0}}) begin
                        // Divide by zero bypasses the iteration entirely.
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                        result_d = {div_data1_i, {DATA_W{1'b1}}};
                    end else begin
                        state_d = DIV_BUSY;
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (!div_start_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = rem_step_s;
                    dvd_d = dvd_step_s;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                        result_d = {cond_neg(rem_step_s, r_neg_q), cond_neg(dvd_step_s, q_neg_q)};
                    end else begin
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= {CNT_W{1'b0}};
            rem_q    <= {DATA_W{1'b0}};
            dvd_q    <= {DATA_W{1'b0}};
            dsr_q    <= {DATA_W{1'b0}};
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= {(2*DATA_W){1'b0}};
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign div_result_o = result_q;
    assign div_done_o   = done_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus randomized ops, aborts and back-to-back issue.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] d1 = 32'd0;
    logic [31:0] d2 = 32'd0;
    logic [63:0] res;
    logic        done;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    logic        prev_done = 1'b0;
    logic [63:0] prev_res = 64'd0;
    logic        in_done = 1'b0;

    div_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_start_i  (div_start),
        .div_signed_i (div_signed),
        .div_data1_i  (d1),
        .div_data2_i  (d2),
        .div_result_o (res),
        .div_done_o   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sbv, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
        end else begin
            sa  = {32'd0, a};
            sbv = {32'd0, b};
        end
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: pops an expectation on each done pulse; otherwise the result must hold still.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            prev_done = 1'b0;
            prev_res  = 64'd0;
        end else begin
            if (done) begin
                n_vec++;
                if (prev_done) begin
                    n_miss++;
                    $display("FAIL done_pulse: done high two cycles in a row at cycle %0d, required single pulse", cyc);
                end
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_done: done with result %h at cycle %0d, required no pulse", res, cyc);
                end else begin
                    e = sb_q.pop_front();
                    n_vec++;
                    if (res !== e.res) begin
                        n_miss++;
                        $display("FAIL result: got %h, expected %h", res, e.res);
                    end
                    n_vec++;
                    if (cyc - e.acc + 1 != e.lat) begin
                        n_miss++;
                        $display("FAIL latency: got %0d cycles, expected %0d", cyc - e.acc + 1, e.lat);
                    end
                end
            end else begin
                n_vec++;
                if (res !== prev_res) begin
                    n_miss++;
                    $display("FAIL result_hold: changed %h -> %h without done at cycle %0d", prev_res, res, cyc);
                end
            end
            prev_done = done;
            prev_res  = res;
        end
    end

    // Issue one op (called at a negedge) and return at the negedge of its done cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp_res, input logic b2b);
        exp_t x;
        d1 = a;
        d2 = b;
        div_signed = s;
        div_start = 1'b1;
        x.res = exp_res;
        x.acc = cyc + (b2b ? 2 : 1);
        x.lat = (b == 32'd0) ? 1 : 33;
        sb_q.push_back(x);
        repeat (b2b ? 2 : 1) @(negedge clk);
        d1 = $urandom;
        d2 = $urandom;
        div_signed = 1'($urandom_range(0, 1));
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        n_vec++;
        if (!done) begin
            n_miss++;
            $display("FAIL timeout: no done for %h / %h signed=%0d, expected result %h", a, b, s, exp_res);
        end
        in_done = 1'b1;
    endtask

    task automatic go_idle();
        div_start = 1'b0;
        @(negedge clk);
        in_done = 1'b0;
    endtask

    // Start an op and drop the request during BUSY cycle k.
    task automatic do_abort(input logic [31:0] a, input logic [31:0] b, input logic s, input int k);
        d1 = a;
        d2 = b;
        div_signed = s;
        div_start = 1'b1;
        @(negedge clk);
        d1 = $urandom;
        d2 = $urandom;
        repeat (k - 1) @(negedge clk);
        div_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          kind;

        repeat (3) @(negedge clk);
        n_vec++;
        if (res !== 64'd0) begin
            n_miss++;
            $display("FAIL reset_result: got %h, expected %h", res, 64'd0);
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_done: got %b, expected 0", done);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);

        do_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);
        go_idle();
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        go_idle();
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 1'b0);
        go_idle();
        do_op(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b0);
        go_idle();
        do_op(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b0);
        go_idle();
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 1'b0);
        go_idle();
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}, 1'b0);
        go_idle();

        do_abort(32'd1000, 32'd3, 1'b0, 10);
        do_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 1'b0);
        go_idle();

        // Asynchronous reset in the middle of an operation.
        d1 = 32'd12345;
        d2 = 32'd17;
        div_signed = 1'b0;
        div_start = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (res !== 64'd0) begin
            n_miss++;
            $display("FAIL async_reset_result: got %h, expected %h", res, 64'd0);
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_miss++;
            $display("FAIL async_reset_done: got %b, expected 0", done);
        end
        div_start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        do_op(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 1'b0);
        do_op(32'd51, 32'd5, 1'b0, {32'd1, 32'd10}, 1'b1);
        go_idle();

        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 9));
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (kind == 0) b = 32'd0;
            if (kind >= 1 && kind <= 3) b = 32'($urandom_range(1, 255));
            if (kind == 4) begin
                a = 32'h8000_0000;
                if ($urandom_range(0, 1) == 1) b = 32'hFFFF_FFFF;
            end
            if (kind == 5) a = 32'($urandom_range(0, 1000));
            if (kind == 9) begin
                if (in_done) go_idle();
                if (b == 32'd0) b = 32'd1;
                do_abort(a, b, s, int'($urandom_range(1, 30)));
            end else if (in_done && $urandom_range(0, 2) == 0) begin
                do_op(a, b, s, ref_div(a, b, s), 1'b1);
            end else begin
                if (in_done) go_idle();
                do_op(a, b, s, ref_div(a, b, s), 1'b0);
            end
        end
        go_idle();
        repeat (3) @(negedge clk);

        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL outstanding: %0d expected results never delivered, required 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
